// File: rtl/float_mult_pipe_if.sv
// Handshake bundle for the pipelined float multiplier: operand channel in,
// product channel out, each with its own valid/ready pair.
interface float_mult_pipe_if #(
    parameter int W     = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_p;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, out_flags
    );
endinterface

// File: rtl/float_mult_pipe.sv
// Three-stage floating-point multiplier with valid/ready backpressure.
// S1 decodes and classifies, S2 multiplies significands, S3 normalises,
// rounds to nearest-even, handles specials and packs the result.
// Subnormal inputs are flushed to signed zero; no subnormal outputs.
module float_mult_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int SAT   = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    float_mult_pipe_if.slave bus
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int EW     = EXP_W + 2;
    localparam int PW     = 2*MAN_W + 2;
    localparam int STAGES = 3;
    localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W-1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_e;

    // pipeline control
    logic [STAGES:1]       r_vld_pipe;
    logic                  w_adv;
    logic                  w_take;

    // S1 decode
    logic [EXP_W-1:0]      w_ea, w_eb;
    logic [MAN_W-1:0]      w_ma, w_mb;
    logic                  w_za, w_zb, w_ia, w_ib, w_na, w_nb;
    spec_e                 w_spec;
    logic signed [EW-1:0]  w_esum;

    logic                  r_s1_sign;
    logic signed [EW-1:0]  r_s1_exp;
    logic [MAN_W:0]        r_s1_ma, r_s1_mb;
    spec_e                 r_s1_spec;
    logic [TAG_W-1:0]      r_s1_tag;

    // S2 product
    logic                  r_s2_sign;
    logic signed [EW-1:0]  r_s2_exp;
    logic [PW-1:0]         r_s2_prod;
    spec_e                 r_s2_spec;
    logic [TAG_W-1:0]      r_s2_tag;

    // S3 normalise / round / pack
    logic                  w_shift;
    logic [PW-2:0]         w_norm;
    logic [MAN_W-1:0]      w_man;
    logic                  w_guard, w_sticky, w_rnd_up;
    logic [MAN_W:0]        w_man_r;
    logic signed [EW-1:0]  w_exp_r;
    logic                  w_ovf, w_unf;
    logic [W-1:0]          w_p;
    logic [2:0]            w_flags;

    logic [W-1:0]          r_out_p;
    logic [TAG_W-1:0]      r_out_tag;
    logic [2:0]            r_out_flags;

    // every stage moves together; a stalled output freezes the whole pipe
    assign w_adv        = !r_vld_pipe[STAGES] || bus.out_ready;
    assign w_take       = bus.in_valid && w_adv;
    assign bus.in_ready = w_adv;

    assign w_ea = bus.in_a[W-2 -: EXP_W];
    assign w_eb = bus.in_b[W-2 -: EXP_W];
    assign w_ma = bus.in_a[MAN_W-1:0];
    assign w_mb = bus.in_b[MAN_W-1:0];
    assign w_za = (w_ea == '0);
    assign w_zb = (w_eb == '0);
    assign w_ia = (&w_ea) && (w_ma == '0);
    assign w_ib = (&w_eb) && (w_mb == '0);
    assign w_na = (&w_ea) && (w_ma != '0);
    assign w_nb = (&w_eb) && (w_mb != '0);
    assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_S;

    // special-case classification in priority order: NaN, inf, zero
    always_comb begin
        w_spec = SP_NONE;
        if (w_na || w_nb || (w_ia && w_zb) || (w_ib && w_za)) w_spec = SP_NAN;
        else if (w_ia || w_ib)                               w_spec = SP_INF;
        else if (w_za || w_zb)                               w_spec = SP_ZERO;
    end

    // stage valid bits shift forward on each advance; bubbles travel as 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_vld_pipe <= '0;
        else if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_take};
    end

    // S1: capture sign, exponent sum, significands with hidden bit, class
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_ma   <= '0;
            r_s1_mb   <= '0;
            r_s1_spec <= SP_NONE;
            r_s1_tag  <= '0;
        end else if (w_take) begin
            r_s1_sign <= bus.in_a[W-1] ^ bus.in_b[W-1];
            r_s1_exp  <= w_esum;
            r_s1_ma   <= {1'b1, w_ma};
            r_s1_mb   <= {1'b1, w_mb};
            r_s1_spec <= w_spec;
            r_s1_tag  <= bus.in_tag;
        end
    end

    // S2: full-width significand product, value in [1,4)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_sign <= 1'b0;
            r_s2_exp  <= '0;
            r_s2_prod <= '0;
            r_s2_spec <= SP_NONE;
            r_s2_tag  <= '0;
        end else if (w_adv && r_vld_pipe[1]) begin
            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= r_s1_exp;
            r_s2_prod <= PW'(r_s1_ma) * PW'(r_s1_mb);
            r_s2_spec <= r_s1_spec;
            r_s2_tag  <= r_s1_tag;
        end
    end

    // align so the leading one sits just above the kept mantissa bits
    assign w_shift  = r_s2_prod[PW-1];
    assign w_norm   = w_shift ? r_s2_prod[PW-2:0] : {r_s2_prod[PW-3:0], 1'b0};
    assign w_man    = w_norm[PW-2 -: MAN_W];
    assign w_guard  = w_norm[MAN_W];
    assign w_sticky = |w_norm[MAN_W-1:0];
    assign w_rnd_up = w_guard && (w_sticky || w_man[0]);
    // a carry out of the mantissa leaves the low bits zero, only bumping E
    assign w_man_r  = {1'b0, w_man} + {{MAN_W{1'b0}}, w_rnd_up};
    assign w_exp_r  = r_s2_exp + EW'(w_shift) + EW'(w_man_r[MAN_W]);
    assign w_ovf    = !w_exp_r[EW-1] && (w_exp_r >= EMAX_S);
    assign w_unf    = w_exp_r[EW-1] || (w_exp_r == '0);

    // result packing and flags {invalid, overflow, underflow}
    always_comb begin
        w_p     = {r_s2_sign, w_exp_r[EXP_W-1:0], w_man_r[MAN_W-1:0]};
        w_flags = 3'b000;
        case (r_s2_spec)
            SP_NAN: begin
                w_p     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                w_flags = 3'b100;
            end
            SP_INF:  w_p = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SP_ZERO: w_p = {r_s2_sign, {(W-1){1'b0}}};
            default: begin
                if (w_ovf) begin
                    w_flags = 3'b010;
                    if (SAT != 0) w_p = {r_s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                    else          w_p = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (w_unf) begin
                    w_flags = 3'b001;
                    w_p     = {r_s2_sign, {(W-1){1'b0}}};
                end
            end
        endcase
    end

    // S3: output registers, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_p     <= '0;
            r_out_tag   <= '0;
            r_out_flags <= '0;
        end else if (w_adv && r_vld_pipe[2]) begin
            r_out_p     <= w_p;
            r_out_tag   <= r_s2_tag;
            r_out_flags <= w_flags;
        end
    end

    assign bus.out_valid = r_vld_pipe[STAGES];
    assign bus.out_p     = r_out_p;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_flags = r_out_flags;
endmodule

// File: tb/tb_float_mult_pipe.sv
// Bench for float_mult_pipe (half precision). Two instances share one
// stimulus stream: one wraps overflow to infinity, one saturates.
module tb_float_mult_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    float_mult_pipe_if #(.W(16), .TAG_W(4)) bus0 ();
    float_mult_pipe_if #(.W(16), .TAG_W(4)) bus1 ();

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_a      = bus0.in_a;
    assign bus1.in_b      = bus0.in_b;
    assign bus1.in_tag    = bus0.in_tag;
    assign bus1.out_ready = bus0.out_ready;

    float_mult_pipe #(.EXP_W(5), .MAN_W(10), .SAT(0), .TAG_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    float_mult_pipe #(.EXP_W(5), .MAN_W(10), .SAT(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic [3:0]  t;
        logic [2:0]  f;
        logic [15:0] p;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer product of significands, then rounded to
    // 11 significant bits by division/remainder against the halfway point.
    function automatic exp_t ref_mul(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] t, input bit sat);
        exp_t   r;
        int     ea, eb, ma, mb, sh, e;
        bit     s, za, zb, ia, ib, na, nb;
        longint pr, q, rem, half;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        s  = a[15] ^ b[15];
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 31) && (ma == 0); ib = (eb == 31) && (mb == 0);
        na = (ea == 31) && (ma != 0); nb = (eb == 31) && (mb != 0);
        r.t = t; r.f = 3'b000;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r.f = 3'b100; r.p = 16'h7E00; return r;
        end
        if (ia || ib) begin r.p = {s, 15'h7C00}; return r; end
        if (za || zb) begin r.p = {s, 15'h0000}; return r; end
        pr   = longint'(1024 + ma) * longint'(1024 + mb);
        sh   = (pr >= (longint'(1) << 21)) ? 11 : 10;
        q    = pr >> sh;
        rem  = pr - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 2048) begin q = 1024; sh = sh + 1; end
        e = sh + ea + eb - 25;
        if (e >= 31) begin
            r.f = 3'b010;
            r.p = sat ? {s, 15'h7BFF} : {s, 15'h7C00};
        end else if (e <= 0) begin
            r.f = 3'b001;
            r.p = {s, 15'h0000};
        end else begin
            r.p = {s, 5'(e), 10'(q)};
        end
        return r;
    endfunction

    function automatic logic [15:0] rnd_half();
        logic [4:0] e;
        logic [9:0] m;
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       e = 5'd0;
            1:       e = 5'd31;
            2, 3:    e = 5'($urandom_range(1, 30));
            default: e = 5'($urandom_range(8, 22));
        endcase
        m = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom);
        return {1'($urandom), e, m};
    endfunction

    task automatic push_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        q0.push_back(ref_mul(a, b, t, 1'b0));
        q1.push_back(ref_mul(a, b, t, 1'b1));
    endtask

    task automatic push_const(input logic [15:0] p0, input logic [2:0] f0,
                              input logic [15:0] p1, input logic [2:0] f1, input logic [3:0] t);
        exp_t e0, e1;
        e0.t = t; e0.f = f0; e0.p = p0;
        e1.t = t; e1.f = f1; e1.p = p1;
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // Scoreboard: every handshake on the output must match the oldest entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) chk("spurious0", {31'b0, bus0.out_valid}, 32'd0);
            else chk("res0", {bus0.out_tag, bus0.out_flags, bus0.out_p}, q0.pop_front());
        end
        if (rst_n === 1'b1 && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) chk("spurious1", {31'b0, bus1.out_valid}, 32'd0);
            else chk("res1", {bus1.out_tag, bus1.out_flags, bus1.out_p}, q1.pop_front());
        end
    end

    task automatic drain();
        for (int k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) begin
            @(posedge clk); #1;
        end
        chk("drain0", q0.size(), 32'd0);
        chk("drain1", q1.size(), 32'd0);
    endtask

    // single operand pair into an empty pipe; out_valid must rise on the 3rd edge
    task automatic lat_check(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                             input logic [15:0] p0, input logic [2:0] f0,
                             input logic [15:0] p1, input logic [2:0] f1);
        bus0.in_a = a; bus0.in_b = b; bus0.in_tag = t; bus0.in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", {31'b0, bus0.in_ready}, 32'd1);
        if (bus0.in_ready) push_const(p0, f0, p1, f1, t);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        chk("lat_edge1", {31'b0, bus0.out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2", {31'b0, bus0.out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_edge3", {31'b0, bus0.out_valid}, 32'd1);
        drain();
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                            input logic [15:0] p0, input logic [2:0] f0,
                            input logic [15:0] p1, input logic [2:0] f1);
        bit acc = 0;
        bus0.in_a = a; bus0.in_b = b; bus0.in_tag = t; bus0.in_valid = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (bus0.in_ready) begin push_const(p0, f0, p1, f1, t); acc = 1; end
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0;
        chk("dir_accept", {31'b0, acc}, 32'd1);
        drain();
    endtask

    logic [15:0] bp_a [6] = '{16'h3C00, 16'h3E00, 16'h3C01, 16'h7BFF, 16'h4248, 16'hC500};
    logic [15:0] bp_b [6] = '{16'h4000, 16'h3E00, 16'h3E00, 16'h4000, 16'h3555, 16'h4A01};

    initial begin
        logic [22:0] held;
        bit          have_held;
        int          idx, sent;
        bit          acc;
        logic [15:0] ra, rb;

        rst_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_tag = '0;
        bus0.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, bus0.out_valid}, 32'd0);
        chk("rst_out_p",     {16'b0, bus0.out_p}, 32'd0);
        chk("rst_out_tag",   {28'b0, bus0.out_tag}, 32'd0);
        chk("rst_out_flags", {29'b0, bus0.out_flags}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'b0, bus0.in_ready}, 32'd1);

        // basic function and latency
        lat_check(16'h3C00, 16'h4000, 4'h5, 16'h4000, 3'b000, 16'h4000, 3'b000);

        // directed vectors: normal, rounding, overflow/underflow, specials
        directed(16'h3E00, 16'h3E00, 4'h1, 16'h4080, 3'b000, 16'h4080, 3'b000);
        directed(16'h3C01, 16'h3E00, 4'h2, 16'h3E02, 3'b000, 16'h3E02, 3'b000);
        directed(16'h3C03, 16'h3E00, 4'h3, 16'h3E04, 3'b000, 16'h3E04, 3'b000);
        directed(16'h3C01, 16'h3C01, 4'h4, 16'h3C02, 3'b000, 16'h3C02, 3'b000);
        directed(16'h7BFF, 16'h4000, 4'h6, 16'h7C00, 3'b010, 16'h7BFF, 3'b010);
        directed(16'h0400, 16'h3800, 4'h7, 16'h0000, 3'b001, 16'h0000, 3'b001);
        directed(16'h8400, 16'h3800, 4'h8, 16'h8000, 3'b001, 16'h8000, 3'b001);
        directed(16'h7C00, 16'h0000, 4'h9, 16'h7E00, 3'b100, 16'h7E00, 3'b100);
        directed(16'hFC00, 16'h4000, 4'hA, 16'hFC00, 3'b000, 16'hFC00, 3'b000);
        directed(16'h7E01, 16'h3C00, 4'hB, 16'h7E00, 3'b100, 16'h7E00, 3'b100);
        directed(16'h8000, 16'h4000, 4'hC, 16'h8000, 3'b000, 16'h8000, 3'b000);

        // backpressure: six back-to-back pairs, output stalled for cycles 3..7
        idx = 0; have_held = 0; held = '0;
        for (int c = 0; c < 60 && (idx < 6 || q0.size() != 0); c++) begin
            bus0.out_ready = !(c >= 3 && c < 8);
            if (idx < 6) begin
                bus0.in_valid = 1'b1; bus0.in_a = bp_a[idx]; bus0.in_b = bp_b[idx];
                bus0.in_tag = 4'(idx + 8);
            end else begin
                bus0.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus0.out_valid && !bus0.out_ready) begin
                chk("bp_in_ready", {31'b0, bus0.in_ready}, 32'd0);
                if (have_held) chk("bp_hold", {9'b0, bus0.out_tag, bus0.out_flags, bus0.out_p}, {9'b0, held});
                held = {bus0.out_tag, bus0.out_flags, bus0.out_p};
                have_held = 1;
            end else begin
                have_held = 0;
            end
            if (bus0.in_valid && bus0.in_ready) begin
                push_model(bus0.in_a, bus0.in_b, bus0.in_tag);
                idx++;
            end
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        chk("bp_sent", idx, 32'd6);
        drain();

        // randomized stream with random input gaps and output stalls
        sent = 0;
        for (int c = 0; c < 3000 && sent < 300; c++) begin
            if (!bus0.in_valid && $urandom_range(0, 4) != 0) begin
                ra = rnd_half(); rb = rnd_half();
                bus0.in_a = ra; bus0.in_b = rb; bus0.in_tag = 4'($urandom);
                bus0.in_valid = 1'b1;
            end
            @(negedge clk);
            acc = bus0.in_valid && bus0.in_ready;
            if (acc) begin
                push_model(bus0.in_a, bus0.in_b, bus0.in_tag);
                sent++;
            end
            @(posedge clk); #1;
            if (acc) bus0.in_valid = 1'b0;
            bus0.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        chk("rnd_sent", sent, 32'd300);
        drain();

        // reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            bus0.in_a = rnd_half(); bus0.in_b = 16'h3C00; bus0.in_tag = 4'(i + 1);
            bus0.in_valid = 1'b1;
            @(negedge clk);
            if (bus0.in_ready) push_model(bus0.in_a, bus0.in_b, bus0.in_tag);
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid0", {31'b0, bus0.out_valid}, 32'd0);
        chk("mid_rst_valid1", {31'b0, bus1.out_valid}, 32'd0);
        chk("mid_rst_p",      {16'b0, bus0.out_p}, 32'd0);
        chk("mid_rst_tag",    {28'b0, bus0.out_tag}, 32'd0);
        chk("mid_rst_flags",  {29'b0, bus0.out_flags}, 32'd0);
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", {31'b0, bus0.out_valid}, 32'd0);
        end
        lat_check(16'h3E00, 16'h3E00, 4'hD, 16'h4080, 3'b000, 16'h4080, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/float_mult_pipe.md
Name: float_mult_pipe

Overview:
- Parametrised, pipelined IEEE-style floating-point multiplier; next generation of the combinational half-precision multiplier in the CNN datapath.
- Adds the following: configurable exponent/mantissa widths, 3-stage pipeline with valid/ready backpressure, round-to-nearest-even, specials handling (zero/inf/NaN), optional saturation, exception flags, and a sideband tag.
- Sits between the weight/activation fetch and the accumulator in the convolution engine.

Parameters:
- EXP_W, 5: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10: stored mantissa width; word width W = 1+EXP_W+MAN_W.
- SAT, 0: 1 = overflow saturates to max finite; 0 = overflow gives infinity.
- TAG_W, 4: width of the sideband tag carried alongside each operand pair (e.g. channel index).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block accepts the pair this cycle.
- in_a, input, W: operand A.
- in_b, input, W: operand B.
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_p, output, W: product.
- out_tag, output, TAG_W: tag of this result.
- out_flags, output, 3: {invalid, overflow, underflow} for this result.

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits = 0; out_valid = 0; out_p = 0; out_tag = 0; out_flags = 0.
  - in_ready = 1 after reset releases.
  - Reset mid-operation discards all in-flight results; none reappear after release.
- Pipeline:
  - S1: decode, sign XOR, exponent sum, special detection.
  - S2: (MAN_W+1)x(MAN_W+1) mantissa multiply.
  - S3: normalise, round, pack, flags.
  - Latency is 3 cycles from accepted input to out_valid with out_ready held high; throughput is 1 per cycle.
- Handshake:
  - A transfer occurs when valid && ready.
  - Global enable: adv = !out_valid || out_ready; in_ready = adv.
  - When adv = 0, all stages hold; out_p, out_tag and out_flags stay stable while out_valid = 1 && !out_ready.
  - Bubbles propagate as stage valid = 0.
  - No result is dropped or duplicated under any out_ready pattern.
- Input classes:
  - exp field 0: zero; subnormals are treated as zero, keeping the sign.
  - exp field all-ones with mantissa 0: infinity.
  - exp field all-ones with mantissa non-zero: NaN.
- Specials (priority order):
  1. NaN on either input, or inf*zero: canonical quiet NaN (sign 0, exp all-ones, mantissa MSB = 1, rest 0); invalid = 1.
  2. inf*finite or inf*inf: signed infinity; no flags.
  3. zero*finite: signed zero; no flags.
- Normal path:
  - Significands 1.m; product P has 2*MAN_W+2 bits in [1,4).
  - If the P MSB is set, shift right by 1 and add 1 to the exponent.
  - Biased exponent E = eA + eB - bias (+1 if shifted), computed signed in EXP_W+2 bits.
- Rounding: round-to-nearest-even using guard bit plus sticky (OR of all lower bits).
  - If the mantissa carries out on round-up, mantissa = 0 and E += 1.
- Overflow: E >= 2^EXP_W - 1 after rounding.
  - SAT=0: signed infinity. SAT=1: signed max finite (exp all-ones minus 1, mantissa all-ones).
  - overflow = 1 in both cases.
- Underflow: E <= 0 after rounding → signed zero, underflow = 1 (flush-to-zero, no subnormal output).
- Tag: in_tag travels with its operands unchanged.

Test Plan (EXP_W=5, MAN_W=10, SAT=0 unless stated):
- 0x3C00*0x4000 -> 0x4000; 0x3E00*0x3E00 -> 0x4080; flags 0; out_valid exactly 3 cycles after acceptance; tag 0x5 returned as 0x5.
- Rounding:
  - 0x3C01*0x3E00 (tie, odd) -> 0x3E02.
  - 0x3C03*0x3E00 (tie, even) -> 0x3E04.
  - 0x3C01*0x3C01 -> 0x3C02.
- Overflow/underflow:
  - 0x7BFF*0x4000 -> 0x7C00 with overflow=1; with SAT=1 -> 0x7BFF with overflow=1.
  - 0x0400*0x3800 -> 0x0000 with underflow=1; 0x8400*0x3800 -> 0x8000 with underflow=1.
- Specials:
  - 0x7C00*0x0000 -> 0x7E00 with invalid=1.
  - 0xFC00*0x4000 -> 0xFC00.
  - 0x7E01*0x3C00 -> 0x7E00 with invalid=1.
  - 0x8000*0x4000 -> 0x8000.
- Backpressure:
  - Stream 6 back-to-back pairs with out_ready low for 5 cycles mid-stream.
  - Required: in_ready low while stalled, out_p stable, all 6 results in order with correct tags, none lost or duplicated.
- Reset: assert rst_n low with 3 results in flight -> outputs 0 immediately; after release no stale out_valid; the next input yields a correct result at latency 3.
